note_sequencer: RTL

Plays a programmed melody by stepping through a 16-entry note table and driving the 12-bit `freq` bus that feeds the tone generator. It is the alternative source to the switch-based note selector. Each note lasts a programmed number of beats and ends in a short silent gap. Playback is controlled by start/stop pulses, with optional looping.

---
 rtl/note_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a 16-entry programmable note table and drives
// the tone generator frequency bus. Each note lasts beats*TICKS_PER_BEAT
// cycles and ends in a silent gap of GAP_TICKS cycles (the final FETCH cycle
// of the gap included). Start/stop pulses control playback; loop_en makes the
// sequence wrap to entry 0 instead of finishing.
module note_sequencer #(
   parameter int unsigned TICKS_PER_BEAT = 25_000_000,
   parameter int unsigned GAP_TICKS      = 2_500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [7:0]  prog_data,
   output logic [11:0] freq,
   output logic        playing,
   output logic [3:0]  step,
   output logic        done
);

   localparam int unsigned CW = $clog2(15 * TICKS_PER_BEAT);

   localparam logic [CW-1:0] TPB_W     = CW'(TICKS_PER_BEAT);
   localparam logic [CW-1:0] SOUND_SUB = CW'(GAP_TICKS + 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 2);
   localparam logic [CW-1:0] ONE       = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SOUND,
      GAP
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   freq_q, freq_d;
   logic [3:0]    step_q, step_d;
   logic          done_q, done_d;

   logic [7:0]    table_q [16];

   logic [7:0]    entry;
   logic [3:0]    code;
   logic [3:0]    beats;
   logic [11:0]   note_freq;
   logic [CW-1:0] note_len;

   // Note table: cleared on reset, written whenever prog_we is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 16; i++) begin
            table_q[i] <= '0;
         end
      end else if (prog_we) begin
         table_q[prog_addr] <= prog_data;
      end
   end

   // Decode the current entry: note code to Hz and beats to sounding length.
   always_comb begin
      entry = table_q[step_q];
      code  = entry[3:0];
      beats = entry[7:4];
      unique case (code)
         4'd1:    note_freq = 12'd440;
         4'd2:    note_freq = 12'd493;
         4'd3:    note_freq = 12'd523;
         4'd4:    note_freq = 12'd587;
         4'd5:    note_freq = 12'd659;
         4'd6:    note_freq = 12'd698;
         4'd7:    note_freq = 12'd783;
         4'd8:    note_freq = 12'd880;
         default: note_freq = '0;
      endcase
      // The counter width holds 15*TICKS_PER_BEAT, so the product cannot wrap.
      note_len = CW'(beats) * TPB_W - SOUND_SUB;
   end

   // State register together with the registered outputs and duration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         freq_q  <= '0;
         step_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         freq_q  <= freq_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; stop overrides everything, including a same-cycle start.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      freq_d  = freq_q;
      step_d  = step_q;
      done_d  = 1'b0;
      if (stop) begin
         state_d = IDLE;
         freq_d  = '0;
         step_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               freq_d = '0;
               step_d = '0;
               if (start) begin
                  state_d = FETCH;
               end
            end
            FETCH: begin
               if (beats == 4'd0) begin
                  // An end marker at entry 0 never loops, so an empty table ends.
                  if ((step_q != 4'd0) && loop_en) begin
                     step_d = '0;
                  end else begin
                     state_d = IDLE;
                     step_d  = '0;
                     done_d  = 1'b1;
                  end
               end else begin
                  freq_d  = note_freq;
                  cnt_d   = note_len;
                  state_d = SOUND;
               end
            end
            SOUND: begin
               if (cnt_q == '0) begin
                  freq_d  = '0;
                  cnt_d   = GAP_LOAD;
                  state_d = GAP;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  if (step_q == 4'd15) begin
                     step_d = '0;
                     if (loop_en) begin
                        state_d = FETCH;
                     end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     step_d  = step_q + 4'd1;
                     state_d = FETCH;
                  end
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode from registered state.
   always_comb begin
      playing = (state_q != IDLE);
      freq    = freq_q;
      step    = step_q;
      done    = done_q;
   end

endmodule
